// File: rtl/data_mem_responder_if.sv
// Request/response channel between the CPU memory stage and the data-memory responder.
// valid/ready: a beat transfers on a rising edge where both are high; the source holds its payload until then.
interface data_mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Slow data memory serving one load/store at a time over valid/ready channels.
// Optional DATA_MEM_WRITE_PROTECT_EN makes addresses 0..3 read-only (stores answered with rsp_err).
module data_mem_responder #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 4,
  parameter int WAIT_CYCLES   = 2,
  parameter int INIT_IDENTITY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              access;
  logic              rsp_hs;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_protect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = WAIT_LOAD;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait cycles the access happens on the accepting edge, so it
  // must use the live request rather than the not-yet-latched copy.
  always_comb begin
    if (state == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

`ifdef DATA_MEM_WRITE_PROTECT_EN
  assign acc_protect = acc_write && ((acc_addr >> 2) == '0);
`else
  assign acc_protect = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      if (access) begin
        rdata_q <= (acc_write && !acc_protect) ? acc_wdata : mem[acc_addr];
        err_q   <= acc_protect;
      end else if (rsp_hs) begin
        err_q <= 1'b0;
      end
    end
  end

  // Contents are reinitialised by reset, so an uncommitted store is simply lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (INIT_IDENTITY != 0) ? DATA_W'(i) : '0;
      end
    end else if (access && acc_write && !acc_protect) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait cycles, one with none.
// Expected {rsp_err, rsp_rdata} values are queued at issue time and popped by per-instance monitors.
module tb_data_mem_responder;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int WA = 2;
  localparam int WZ = 0;

`ifdef DATA_MEM_WRITE_PROTECT_EN
  localparam logic [4:0] EXP_ST2 = 5'h12;
  localparam logic [4:0] EXP_LD2 = 5'h02;
`else
  localparam logic [4:0] EXP_ST2 = 5'h0E;
  localparam logic [4:0] EXP_LD2 = 5'h0E;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) ba ();
  data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bz ();

  logic       busy_a, busy_z;
  logic [1:0] st_a, st_z;

  data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA), .INIT_IDENTITY(1)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .bus       (ba),
    .busy      (busy_a),
    .state_dbg (st_a)
  );

  data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WZ), .INIT_IDENTITY(1)) dut_z (
    .clock     (clock),
    .reset     (reset),
    .bus       (bz),
    .busy      (busy_z),
    .state_dbg (st_z)
  );

  int checks = 0;
  int errors = 0;

  logic [DW:0] exp_q_a[$];
  logic [DW:0] exp_q_z[$];

  bit          cur_sel;
  logic        cur_req_ready, cur_rsp_valid, cur_busy;
  logic [DW-1:0] cur_rdata;
  logic [1:0]  cur_state;

  always_comb begin
    cur_req_ready = cur_sel ? bz.req_ready : ba.req_ready;
    cur_rsp_valid = cur_sel ? bz.rsp_valid : ba.rsp_valid;
    cur_rdata     = cur_sel ? bz.rsp_rdata : ba.rsp_rdata;
    cur_busy      = cur_sel ? busy_z : busy_a;
    cur_state     = cur_sel ? st_z : st_a;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // scoreboard monitors
  always @(negedge clock) begin
    if (!reset && ba.rsp_valid && ba.rsp_ready) begin
      if (exp_q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_a unexpected got %0h want none", {ba.rsp_err, ba.rsp_rdata});
      end else begin
        check("rsp_a", {ba.rsp_err, ba.rsp_rdata}, exp_q_a.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && bz.rsp_valid && bz.rsp_ready) begin
      if (exp_q_z.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_z unexpected got %0h want none", {bz.rsp_err, bz.rsp_rdata});
      end else begin
        check("rsp_z", {bz.rsp_err, bz.rsp_rdata}, exp_q_z.pop_front());
      end
    end
  end

  // driver tasks
  task automatic drive_req(input bit sel, input bit v, input bit wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (sel) begin
      bz.req_valid = v; bz.req_write = wr; bz.req_addr = addr; bz.req_wdata = wdata;
    end else begin
      ba.req_valid = v; ba.req_write = wr; ba.req_addr = addr; ba.req_wdata = wdata;
    end
  endtask

  task automatic set_rsp_ready(input bit sel, input bit r);
    if (sel) bz.rsp_ready = r;
    else     ba.rsp_ready = r;
  endtask

  // Called #1 after a rising edge with the instance idle; returns #1 after the
  // handshake edge. Latency counts edges starting with the accepting edge.
  task automatic issue(input bit sel, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW:0] exp,
                       input int hold, output int acc_cyc);
    int edges;
    cur_sel = sel;
    set_rsp_ready(sel, hold == 0);
    drive_req(sel, 1'b1, wr, addr, wdata);
    if (sel) exp_q_z.push_back(exp);
    else     exp_q_a.push_back(exp);
    @(negedge clock);
    check("req_ready_idle", cur_req_ready, 1);
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    drive_req(sel, 1'b0, 1'b0, '0, '0);
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cur_rsp_valid) break;
      @(posedge clock);
      edges++;
    end
    check("latency", edges, (sel ? WZ : WA) + 1);
    check("req_ready_resp", cur_req_ready, 0);
    if (hold > 0) begin
      drive_req(sel, 1'b1, 1'b0, ~addr, '0);
      for (int h = 0; h < hold; h++) begin
        @(posedge clock);
        @(negedge clock);
        check("hold_valid", cur_rsp_valid, 1);
        check("hold_rdata", cur_rdata, exp[DW-1:0]);
        check("hold_req_ready", cur_req_ready, 0);
      end
      @(posedge clock);
      #1;
      drive_req(sel, 1'b0, 1'b0, '0, '0);
      set_rsp_ready(sel, 1'b1);
    end
    @(posedge clock);
    #1;
    check("idle_after_hs", cur_state, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    cur_sel = 1'b0;
    check({tag, "_req_ready"}, ba.req_ready, 1);
    check({tag, "_rsp_valid"}, ba.rsp_valid, 0);
    check({tag, "_rsp_rdata"}, ba.rsp_rdata, 0);
    check({tag, "_rsp_err"},   ba.rsp_err, 0);
    check({tag, "_busy"},      busy_a, 0);
    check({tag, "_state"},     st_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    ba.rsp_ready = 1'b1;
    bz.rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock);
    #1;

    // identity contents, 2 wait cycles
    issue(1'b0, 1'b0, 4'd9, 4'h0, 5'h09, 0, t0);
    // store then load, neighbour untouched
    issue(1'b0, 1'b1, 4'd6, 4'hA, 5'h0A, 0, t0);
    issue(1'b0, 1'b0, 4'd6, 4'h0, 5'h0A, 0, t0);
    issue(1'b0, 1'b0, 4'd7, 4'h0, 5'h07, 0, t0);
    // top address
    issue(1'b0, 1'b1, 4'd15, 4'h0, 5'h00, 0, t0);
    issue(1'b0, 1'b0, 4'd15, 4'h0, 5'h00, 0, t0);

    // zero wait cycles, back-to-back every 2 cycles
    issue(1'b1, 1'b0, 4'd3, 4'h0, 5'h03, 0, t0);
    issue(1'b1, 1'b1, 4'd8, 4'h1, 5'h01, 0, t1);
    issue(1'b1, 1'b0, 4'd8, 4'h0, 5'h01, 0, t2);
    check("issue_interval_1", t1 - t0, 2);
    check("issue_interval_2", t2 - t1, 2);

    // response back-pressure with a stray request
    issue(1'b0, 1'b0, 4'd5, 4'h0, 5'h05, 5, t0);

    // reset while a store waits: store dropped, memory reinitialised
    cur_sel = 1'b0;
    drive_req(1'b0, 1'b1, 1'b1, 4'd12, 4'hF);
    @(negedge clock);
    check("rst_req_ready", ba.req_ready, 1);
    @(posedge clock);
    #1;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    check("rst_busy_wait", busy_a, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    issue(1'b0, 1'b0, 4'd12, 4'h0, 5'h0C, 0, t0);
    issue(1'b0, 1'b0, 4'd6, 4'h0, 5'h06, 0, t0);

    // protected region (or plain store without the macro)
    issue(1'b0, 1'b1, 4'd2, 4'hE, EXP_ST2, 0, t0);
    issue(1'b0, 1'b0, 4'd2, 4'h0, EXP_LD2, 0, t0);
    issue(1'b0, 1'b1, 4'd4, 4'hE, 5'h0E, 0, t0);
    issue(1'b0, 1'b0, 4'd4, 4'h0, 5'h0E, 0, t0);

    repeat (4) @(posedge clock);
    #1;
    check("rdata_persists", ba.rsp_rdata, 4'hE);
    check("exp_q_a_empty", exp_q_a.size(), 0);
    check("exp_q_z_empty", exp_q_z.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the CPU data-memory interface: a 16x4 data memory that serves load/store requests issued by the CPU over a valid/ready request channel and a valid/ready response channel.
- Models a slow memory: a configurable number of wait cycles precedes each access.
- Sits between the CPU's memory-stage signals (address = ALU result, write data = second register read) and the register write-back path, replacing the CPU's zero-latency inline data memory array.
- Serves one transaction at a time, strictly in order.

Parameters:
ADDR_W, 4, address width; depth = 2**ADDR_W words.
DATA_W, 4, data word width.
WAIT_CYCLES, 2, wait cycles inserted between request acceptance and response; legal range 0..15.
INIT_IDENTITY, 1, when 1, reset loads mem[i] = i[DATA_W-1:0]; when 0, reset loads all zeros.

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  CPU presents a request
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response available
rsp_ready  in  1  CPU consumes the response
rsp_rdata  out  DATA_W  load data, or the committed store data on a store
rsp_err  out  1  access rejected (see Optional Feature); 0 otherwise
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clock.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, wait counter = 0.
- Reset initialises memory contents per INIT_IDENTITY.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1, latch req_write, req_addr and req_wdata.
  - If WAIT_CYCLES = 0, go to RESP; otherwise load counter = WAIT_CYCLES - 1 and go to WAIT.
- WAIT:
  - req_ready = 0; request inputs are ignored.
  - Counter decrements each edge. At the edge where the counter is 0, perform the access and go to RESP.
  - Store: mem[addr] <= wdata, and rsp_rdata <= wdata.
  - Load: rsp_rdata <= mem[addr].
- IDLE->RESP direct path (WAIT_CYCLES = 0): the access happens on the accepting edge.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until handshake.
  - On an edge with rsp_ready = 1, go to IDLE with rsp_valid = 0.
  - rsp_ready = 0 holds RESP indefinitely; no timeout.
- No overlap: req_ready is 0 in RESP, so the earliest next acceptance is the edge after returning to IDLE. Minimum issue interval is WAIT_CYCLES+2 cycles.
- Ordering: a load following a store to the same address returns the stored value, because transactions are serialized.
- Address width: the full address range is valid; no out-of-range case exists.
- Reset mid-operation: an uncommitted store in WAIT is dropped and memory is reinitialised; a pending response is discarded.
- Combinational paths: none from req_* to rsp_*; all outputs are registered or decoded from state.
- rsp_rdata persists after handshake until the next access overwrites it.

Optional Feature:
Macro: DATA_MEM_WRITE_PROTECT_EN
- Defined:
  - Addresses 0..3 are read-only.
  - A store to them is accepted and timed normally, but memory is not modified.
  - The response carries rsp_err = 1, and rsp_rdata = the current mem[addr].
  - Loads are unaffected; rsp_err = 1 only on the RESP of a rejected store and is cleared on handshake.
- Not defined: all addresses are writable; rsp_err is constant 0.

Test Plan:
1. Reset, then load addr 9 with INIT_IDENTITY=1, WAIT_CYCLES=2 -> rsp_valid high exactly 3 edges after acceptance, rsp_rdata = 4'h9, rsp_err = 0.
2. Store 4'hA to addr 6, then load addr 6 -> store response rdata = 4'hA; load returns 4'hA; addr 7 still returns 4'h7.
3. WAIT_CYCLES=0: load addr 3 -> rsp_valid the edge after acceptance; back-to-back requests accepted every 2 cycles; req_ready low during RESP.
4. Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready = 0, new req_valid ignored; raise rsp_ready -> IDLE next edge.
5. Store 4'hF to addr 12, assert reset during WAIT -> all outputs return to reset values; load addr 12 afterwards returns 4'hC.
6. With DATA_MEM_WRITE_PROTECT_EN, store 4'hE to addr 2 -> rsp_err = 1, rsp_rdata = 4'h2; load addr 2 returns 4'h2. Same store to addr 4 -> rsp_err = 0, memory updated. Without the macro, the store to addr 2 succeeds.
